// File: rtl/bcd_multiply_seq.sv
// bcd_multiply_seq: sequential BCD multiplier (BCD->binary, shift-add multiply, double-dabble back to BCD).
module bcd_multiply_seq #(
  parameter int N_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   a_bcd,
  input  logic [4*N_DIGITS-1:0]   b_bcd,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [8*N_DIGITS-1:0]   product_bcd
);
  localparam int W  = $clog2(10**N_DIGITS);
  localparam int P  = 2*W;
  localparam int D  = 8*N_DIGITS;
  localparam int CW = $clog2(P+1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, MUL = 3'd2, CONV = 3'd3, DONE = 3'd4;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]          acca_q, acca_d, accb_q, accb_d;
  logic [P-1:0]          prod_q, prod_d;
  logic [D-1:0]          bcd_q, bcd_d, adj, product_q, product_d;
  logic                  err_q, err_d, bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      bad = bad | (a_bcd[4*i+:4] > 4'd9) | (b_bcd[4*i+:4] > 4'd9);
    for (int i = 0; i < 2*N_DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] + (bcd_q[4*i+:4] >= 4'd5 ? 4'd3 : 4'd0);
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acca_d    = acca_q;
    accb_d    = accb_q;
    prod_d    = prod_q;
    bcd_d     = bcd_q;
    product_d = product_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = bad ? DONE : LOAD;
        err_d     = bad;
        product_d = bad ? '0 : product_q;
        opa_d     = a_bcd;
        opb_d     = b_bcd;
        acca_d    = '0;
        accb_d    = '0;
        prod_d    = '0;
        cnt_d     = '0;
      end
      LOAD: begin
        acca_d  = W'(acca_q * 10 + opa_q[4*N_DIGITS-1 -: 4]);
        accb_d  = W'(accb_q * 10 + opb_q[4*N_DIGITS-1 -: 4]);
        opa_d   = opa_q << 4;
        opb_d   = opb_q << 4;
        cnt_d   = (cnt_q == CW'(N_DIGITS-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N_DIGITS-1)) ? MUL : LOAD;
      end
      MUL: begin
        prod_d  = prod_q + (accb_q[0] ? ({{W{1'b0}}, acca_q} << cnt_q) : '0);
        accb_d  = accb_q >> 1;
        bcd_d   = '0;
        cnt_d   = (cnt_q == CW'(W-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W-1)) ? CONV : MUL;
      end
      CONV: begin
        bcd_d     = {adj[D-2:0], prod_q[P-1]};
        prod_d    = prod_q << 1;
        cnt_d     = (cnt_q == CW'(P-1)) ? '0 : cnt_q + 1'b1;
        state_d   = (cnt_q == CW'(P-1)) ? DONE : CONV;
        product_d = (cnt_q == CW'(P-1)) ? {adj[D-2:0], prod_q[P-1]} : product_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acca_q    <= '0;
      accb_q    <= '0;
      prod_q    <= '0;
      bcd_q     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acca_q    <= acca_d;
      accb_q    <= accb_d;
      prod_q    <= prod_d;
      bcd_q     <= bcd_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end
  assign busy        = (state_q == LOAD) | (state_q == MUL) | (state_q == CONV);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign product_bcd = product_q;
endmodule

// File: tb/tb_bcd_multiply_seq.sv
// tb_bcd_multiply_seq: directed vectors plus hand-written multi-cycle sequences for bcd_multiply_seq.
module tb_bcd_multiply_seq;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic [7:0] a_bcd = '0, b_bcd = '0;
  logic [15:0] a4 = '0, b4 = '0;
  logic [3:0] a1 = '0, b1 = '0;
  logic busy, done, err, busy4, done4, err4, busy1, done1, err1;
  logic [15:0] product_bcd;
  logic [31:0] product4;
  logic [7:0] product1;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;

  always #5 clk = ~clk;

  bcd_multiply_seq #(.N_DIGITS(2)) dut (.clk(clk), .reset(reset), .start(start), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .busy(busy), .done(done), .err(err), .product_bcd(product_bcd));
  bcd_multiply_seq #(.N_DIGITS(4)) dut4 (.clk(clk), .reset(reset), .start(start4), .a_bcd(a4), .b_bcd(b4),
    .busy(busy4), .done(done4), .err(err4), .product_bcd(product4));
  bcd_multiply_seq #(.N_DIGITS(1)) dut1 (.clk(clk), .reset(reset), .start(start1), .a_bcd(a1), .b_bcd(b1),
    .busy(busy1), .done(done1), .err(err1), .product_bcd(product1));

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an op, checks busy right after the start edge, returns edges until done, then checks the pulse drops.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic exp_busy, output int lat);
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", {31'd0, busy}, {31'd0, exp_busy});
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    @(posedge clk);
    #1 check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        e;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int lat, dc;
    vecs[0] = '{8'h12, 8'h34, 16'h0408, 1'b0};
    vecs[1] = '{8'h99, 8'h99, 16'h9801, 1'b0};
    vecs[2] = '{8'h00, 8'h57, 16'h0000, 1'b0};
    vecs[3] = '{8'h1A, 8'h05, 16'h0000, 1'b1};
    vecs[4] = '{8'h03, 8'h03, 16'h0009, 1'b0};
    vecs[5] = '{8'h25, 8'h04, 16'h0100, 1'b0};
    vecs[6] = '{8'h0F, 8'h01, 16'h0000, 1'b1};
    vecs[7] = '{8'h64, 8'h75, 16'h4800, 1'b0};
    vecs[8] = '{8'h12, 8'hA0, 16'h0000, 1'b1};
    vecs[9] = '{8'h37, 8'h29, 16'h1073, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_product", {16'd0, product_bcd}, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      op(vecs[i].a, vecs[i].b, !vecs[i].e, lat);
      check($sformatf("latency_%0d", i), lat, vecs[i].e ? 32'd0 : 32'd23);
      check($sformatf("product_%0d", i), {16'd0, product_bcd}, {16'd0, vecs[i].p});
      check($sformatf("err_%0d", i), {31'd0, err}, {31'd0, vecs[i].e});
    end

    // Operand changes and a stray start during an op are ignored.
    dc = done_cnt;
    @(negedge clk);
    a_bcd = 8'h12;
    b_bcd = 8'h34;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a_bcd = 8'h99;
    b_bcd = 8'h99;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("hold_product_midop", {16'd0, product_bcd}, 32'h1073);
    lat = 5;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check("ignore_latency", lat, 32'd23);
    check("ignore_product", {16'd0, product_bcd}, 32'h0408);
    repeat (30) @(posedge clk);
    #1;
    check("ignore_no_second_op", {31'd0, busy}, 32'd0);
    check("ignore_done_count", done_cnt - dc, 32'd1);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    a_bcd = 8'h99;
    b_bcd = 8'h99;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", {16'd0, product_bcd}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk) reset = 1'b0;
    dc = done_cnt;
    repeat (40) @(posedge clk);
    #1 check("abort_no_done", done_cnt - dc, 32'd0);
    op(8'h03, 8'h03, 1'b1, lat);
    check("after_abort_latency", lat, 32'd23);
    check("after_abort_product", {16'd0, product_bcd}, 32'h0009);

    // Four-digit operands.
    @(negedge clk);
    a4 = 16'h9999;
    b4 = 16'h9999;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("n4_latency", lat, 32'd46);
    check("n4_product", product4, 32'h99980001);
    check("n4_err", {31'd0, err4}, 32'd0);

    // One-digit operands.
    @(negedge clk);
    a1 = 4'h7;
    b1 = 4'h8;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check("n1_latency", lat, 32'd13);
    check("n1_product", {24'd0, product1}, 32'h56);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
